pd_pluse_meas: RTL and testbench
================================

PD_PLUSE_MEAS -- requirements
Module: pd_pluse_meas

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on en_in; legal values are 2 and 3.
REQ-002 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 pluse_start  in  1  one-cycle arm/restart strobe.
REQ-005 en_in  in  1  asynchronous pulse line to measure; it carries the pulse-generator enable output.
REQ-006 meas_rd  in  1  one-cycle readback strobe.
REQ-007 meas_choice  in  4  readback segment index, 0..15.
REQ-008 meas_data  out  16  readback segment width in clk_sys cycles.
REQ-009 meas_valid  out  1  one-cycle qualifier for meas_data.
REQ-010 meas_cnt  out  5  number of segments captured, 0..16.
REQ-011 first_level  out  1  en_in level after the first captured edge.
REQ-012 meas_busy  out  1  high in ARM and MEAS.
REQ-013 meas_done  out  1  high in DONE.
REQ-014 meas_tmo  out  1  sticky timeout flag for the current capture.

Function
REQ-015 en_in SHALL pass through SYNC_STAGES flops to give en_s; en_s_d is en_s delayed one cycle; edge = en_s XOR en_s_d.
REQ-016 FSM states SHALL be IDLE, ARM, MEAS, DONE.
REQ-017 pluse_start in any state SHALL set meas_cnt=0 and meas_tmo=0 and move to ARM on the next cycle; buffer contents are left as they are.
REQ-018 ARM: on edge, the block SHALL load width counter wcnt=1, latch first_level=en_s, and move to MEAS; nothing is stored.
REQ-019 MEAS, no edge: wcnt SHALL increment by 1.
REQ-020 MEAS, edge: the block SHALL write wcnt into buf[meas_cnt], increment meas_cnt, and reload wcnt=1.
REQ-021 A segment of N stable en_s cycles SHALL be stored as exactly N, for all N from 1 to 65534.
REQ-022 On the 16th store, the FSM SHALL move to DONE.
REQ-023 MEAS with wcnt=0xFFFF and no edge: the block SHALL store 0xFFFF, increment meas_cnt, set meas_tmo=1, and move to DONE; wcnt never wraps.
REQ-024 If pluse_start and edge occur in the same cycle, restart SHALL win and the edge is ignored.
REQ-025 DONE: the block SHALL hold all outputs until pluse_start or rst; edges are ignored.
REQ-026 The buffer is 16 x 16 bits and SHALL be write-only from the FSM and read-only from the readback port.
REQ-027 Readback: meas_rd at cycle t SHALL give meas_valid=1 at t+1, with meas_data=buf[meas_choice] if meas_choice<meas_cnt, else 0x0000.
REQ-028 Readback SHALL be legal in every state.
REQ-029 A read of an index being written in the same cycle SHALL return the new value.
REQ-030 meas_data SHALL hold its last value when meas_valid=0.
REQ-031 Back-to-back meas_rd SHALL give back-to-back meas_valid.
REQ-032 meas_busy SHALL be 1 exactly in ARM and MEAS; meas_done SHALL be 1 exactly in DONE.

Reset
REQ-033 On rst, the block SHALL enter IDLE next cycle with these values:
- meas_data=0, meas_valid=0, meas_cnt=0, first_level=0
- meas_busy=0, meas_done=0, meas_tmo=0
- wcnt=0, all synchronizer flops 0
REQ-034 rst SHALL take priority over pluse_start and meas_rd.
REQ-035 rst asserted mid-capture SHALL abandon the capture; the buffer need not be cleared, but reads SHALL return 0 because meas_cnt=0.
REQ-036 In IDLE, edges SHALL be ignored.

Verification
REQ-037 Basic capture: pluse_start, then en_in low->high, 5 high, 3 low, 7 high, then a 0xFFFF hold -> meas_cnt=4, buf[0..3]=5,3,7,0xFFFF, first_level=1, meas_tmo=1, DONE.
REQ-038 Full buffer: 17 edges with alternating widths 2 and 4 -> meas_cnt=16, buf[0..15]=2,4,2,4,..., meas_done=1, meas_tmo=0, later edges ignored.
REQ-039 Readback: meas_rd with meas_choice=2 after REQ-037 -> meas_valid=1 one cycle later, meas_data=7; meas_choice=9 -> 0x0000.
REQ-040 Restart: pluse_start mid-MEAS after 3 segments -> meas_cnt=0, ARM; a read of index 0 returns 0 until a new store.
REQ-041 Minimum width: 1-cycle en_s glitches -> stored widths 1; pluse_start coincident with an edge -> no store, state ARM.
REQ-042 Reset: rst during MEAS with meas_cnt=5 -> all outputs 0 and IDLE next cycle; a subsequent read returns 0.

Source files
------------

// File: rtl/pd_pluse_meas_if.sv
// Control and readback bundle of the pulse-width measurement block.
// The master drives the strobes and read index; the slave drives status and read data.
interface pd_pluse_meas_if;
    logic        pluse_start;
    logic        meas_rd;
    logic [3:0]  meas_choice;
    logic [15:0] meas_data;
    logic        meas_valid;
    logic [4:0]  meas_cnt;
    logic        first_level;
    logic        meas_busy;
    logic        meas_done;
    logic        meas_tmo;

    modport master (
        output pluse_start, meas_rd, meas_choice,
        input  meas_data, meas_valid, meas_cnt, first_level, meas_busy, meas_done, meas_tmo
    );

    modport slave (
        input  pluse_start, meas_rd, meas_choice,
        output meas_data, meas_valid, meas_cnt, first_level, meas_busy, meas_done, meas_tmo
    );
endinterface

// File: rtl/pd_pluse_meas.sv
// Measures up to 16 segment widths (in clk_sys cycles) between edges of an asynchronous line.
// Widths are stored in a 16-entry buffer and read back through a one-cycle-latency port.
module pd_pluse_meas #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk_sys,
    input  logic           rst,
    input  logic           en_in,
    pd_pluse_meas_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArm, StMeas, StDone} state_e;

    localparam logic [15:0] WidthMax = 16'hFFFF;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   en_s;
    logic                   en_s_d_q;
    logic                   edge_s;

    state_e      state_q, state_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic        tmo_q, tmo_d;
    logic        busy_q, done_q;
    logic [15:0] data_q, data_d;
    logic        valid_q;
    logic [15:0] mem_q [16];
    logic        wr_en;
    logic [15:0] rd_word;

    assign en_s   = sync_q[SYNC_STAGES-1];
    assign edge_s = en_s ^ en_s_d_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        tmo_d   = tmo_q;
        wr_en   = 1'b0;
        if (bus.pluse_start) begin
            // Restart wins over any edge seen in the same cycle.
            state_d = StArm;
            cnt_d   = 5'd0;
            tmo_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StArm: begin
                    if (edge_s) begin
                        wcnt_d  = 16'd1;
                        first_d = en_s;
                        state_d = StMeas;
                    end
                end
                StMeas: begin
                    if (edge_s || wcnt_q == WidthMax) begin
                        wr_en  = 1'b1;
                        cnt_d  = cnt_q + 5'd1;
                        wcnt_d = 16'd1;
                        if (!edge_s) begin
                            tmo_d   = 1'b1;
                            state_d = StDone;
                        end
                        if (cnt_q == 5'd15) begin
                            state_d = StDone;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 16'd1;
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Forward the word being stored this cycle so a coincident read sees it.
    always_comb begin
        if (wr_en && bus.meas_choice == cnt_q[3:0]) begin
            rd_word = wcnt_q;
        end else begin
            rd_word = mem_q[bus.meas_choice];
        end
        data_d = data_q;
        if (bus.meas_rd) begin
            data_d = ({1'b0, bus.meas_choice} < cnt_d) ? rd_word : 16'h0000;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync_q   <= '0;
            en_s_d_q <= 1'b0;
            state_q  <= StIdle;
            wcnt_q   <= 16'd0;
            cnt_q    <= 5'd0;
            first_q  <= 1'b0;
            tmo_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= 16'h0000;
            valid_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], en_in};
            en_s_d_q <= en_s;
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            tmo_q    <= tmo_d;
            busy_q   <= (state_d == StArm) || (state_d == StMeas);
            done_q   <= (state_d == StDone);
            data_q   <= data_d;
            valid_q  <= bus.meas_rd;
        end
    end

    // Buffer contents survive reset; meas_cnt gates what is readable.
    always_ff @(posedge clk_sys) begin
        if (wr_en && !rst) begin
            mem_q[cnt_q[3:0]] <= wcnt_q;
        end
    end

    assign bus.meas_data   = data_q;
    assign bus.meas_valid  = valid_q;
    assign bus.meas_cnt    = cnt_q;
    assign bus.first_level = first_q;
    assign bus.meas_busy   = busy_q;
    assign bus.meas_done   = done_q;
    assign bus.meas_tmo    = tmo_q;
endmodule

// File: tb/tb_pd_pluse_meas.sv
// Randomised and directed bench for pd_pluse_meas with a segment-list model and a
// read scoreboard drained by an independent monitor.
module tb_pd_pluse_meas;
    localparam int unsigned SyncStages = 2;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rd_t;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    logic en_in   = 1'b0;

    pd_pluse_meas_if bus ();

    pd_pluse_meas #(.SYNC_STAGES(SyncStages)) u_dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .en_in   (en_in),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;
    logic [15:0] last_exp = 16'h0000;
    rd_t         sb_q[$];

    // Model of the capture in terms of the segment list that was driven.
    int          exp_cnt;
    logic [15:0] exp_mem [16];
    bit          exp_first, exp_busy, exp_done, exp_tmo;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_sys) begin
        rd_t e;
        if (mon_en) begin
            if (bus.meas_valid) begin
                if (sb_q.size() == 0) begin
                    check("rd_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rd_data", {16'h0, bus.meas_data}, {16'h0, e.data});
                    check("rd_latency", cyc, e.cyc);
                    last_exp = e.data;
                end
            end else begin
                check("data_hold", {16'h0, bus.meas_data}, {16'h0, last_exp});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic rd(input int idx);
        rd_t e;
        e.data = (idx < exp_cnt) ? exp_mem[idx] : 16'h0000;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
        bus.meas_rd     = 1'b1;
        bus.meas_choice = 4'(idx);
        tick(1);
    endtask

    task automatic rd_end();
        bus.meas_rd = 1'b0;
        tick(3);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) rd(i);
        rd(int'($urandom_range(0, 15)));
        rd_end();
    endtask

    task automatic pulse_start();
        bus.pluse_start = 1'b1;
        tick(1);
        bus.pluse_start = 1'b0;
        exp_cnt  = 0;
        exp_tmo  = 1'b0;
        exp_busy = 1'b1;
        exp_done = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cnt"},   {27'h0, bus.meas_cnt}, exp_cnt);
        check({tag, "_first"}, {31'h0, bus.first_level}, {31'h0, exp_first});
        check({tag, "_busy"},  {31'h0, bus.meas_busy}, {31'h0, exp_busy});
        check({tag, "_done"},  {31'h0, bus.meas_done}, {31'h0, exp_done});
        check({tag, "_tmo"},   {31'h0, bus.meas_tmo}, {31'h0, exp_tmo});
    endtask

    // Hold pre, arm, then drive segments of the given widths; each ends with a toggle.
    task automatic run_capture(input bit pre, input int w[$], input int tail);
        en_in = pre;
        tick(6);
        pulse_start();
        tick(2);
        en_in = ~pre;
        foreach (w[i]) begin
            tick(w[i]);
            en_in = ~en_in;
        end
        tick(tail);
        exp_first = ~pre;
        exp_cnt   = (w.size() < 16) ? w.size() : 16;
        for (int i = 0; i < exp_cnt; i++) exp_mem[i] = 16'(w[i]);
        exp_done  = (w.size() >= 16);
        exp_busy  = !exp_done;
        exp_tmo   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.meas_done && n < budget) begin
            tick(1);
            n++;
        end
        check("done_wait", {31'h0, bus.meas_done}, 32'd1);
    endtask

    task automatic reset_model();
        exp_cnt   = 0;
        exp_first = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_tmo   = 1'b0;
    endtask

    initial begin
        int w[$];
        bit lvl;
        bus.pluse_start = 1'b0;
        bus.meas_rd     = 1'b0;
        bus.meas_choice = 4'd0;
        reset_model();
        tick(3);
        rst = 1'b0;
        check("init_valid", {31'h0, bus.meas_valid}, 32'd0);
        check("init_data", {16'h0, bus.meas_data}, 32'd0);
        check_status("init");
        mon_en = 1'b1;
        tick(2);

        // Basic capture ending in a 0xFFFF timeout.
        w = {5, 3, 7};
        run_capture(1'b0, w, 4);
        wait_done(70000);
        exp_mem[3] = 16'hFFFF;
        exp_cnt    = 4;
        exp_tmo    = 1'b1;
        exp_done   = 1'b1;
        exp_busy   = 1'b0;
        check_status("tmo");
        rd(2);
        rd(9);
        rd_end();
        read_all();

        // Full buffer, extra edges after the 16th store are ignored.
        w = {};
        for (int i = 0; i < 20; i++) w.push_back((i % 2 == 0) ? 2 : 4);
        run_capture(1'b1, w, 6);
        check_status("full");
        read_all();

        // Restart mid-capture after three stores.
        w = {3, 4, 5};
        run_capture(1'b1, w, 6);
        check_status("pre_restart");
        pulse_start();
        check_status("restart");
        rd(0);
        rd_end();
        lvl = ~en_in;
        en_in = ~en_in;
        tick(2);
        en_in = ~en_in;
        tick(2);
        en_in = ~en_in;
        tick(6);
        exp_first  = lvl;
        exp_mem[0] = 16'd2;
        exp_mem[1] = 16'd2;
        exp_cnt    = 2;
        check_status("restart_store");
        read_all();

        // Restart coincident with an edge: the edge is dropped, FSM stays armed.
        en_in = ~en_in;
        tick(SyncStages);
        pulse_start();
        check_status("coinc");
        tick(4);
        check_status("coinc_hold");

        // One-cycle glitches.
        w = {1, 1, 1};
        run_capture(en_in, w, 6);
        check_status("glitch");
        read_all();

        // Reset mid-capture with five stores; reset beats start and read.
        w = {2, 3, 4, 5, 6};
        run_capture(1'b0, w, 6);
        check_status("pre_rst");
        rd(4);
        rd_end();
        rst = 1'b1;
        bus.pluse_start = 1'b1;
        bus.meas_rd     = 1'b1;
        bus.meas_choice = 4'd4;
        tick(1);
        last_exp = 16'h0000;
        rst = 1'b0;
        bus.pluse_start = 1'b0;
        bus.meas_rd     = 1'b0;
        reset_model();
        check("rst_valid", {31'h0, bus.meas_valid}, 32'd0);
        check("rst_data", {16'h0, bus.meas_data}, 32'd0);
        check_status("rst");
        tick(2);
        check_status("rst_idle");
        read_all();

        // Randomised captures.
        for (int it = 0; it < 8; it++) begin
            int k;
            k = $urandom_range(1, 20);
            w = {};
            for (int i = 0; i < k; i++) w.push_back(int'($urandom_range(1, 8)));
            run_capture(1'($urandom_range(0, 1)), w, 6);
            check_status("rand");
            read_all();
        end

        tick(3);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
